// File: rtl/div_pkg.sv
// Shared types and constants for the restoring-divider controller.
package div_pkg;

    // Operand width of the divider datapath.
    localparam int DIV_W = 8;

    // Number of shift/subtract iterations for one DIV_W-bit divide.
    localparam int DIV_ITER = 9;

    // Width of the controller's saturating RUN-cycle counter.
    localparam int CNT_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Every datapath strobe, collected so the decoder can clear them in one go.
    typedef struct packed {
        logic ld_a;
        logic sel_a_init;
        logic ld_b;
        logic sel_b_init;
        logic ld_q;
        logic clr_q;
        logic ld_cnt;
        logic cnt_init;
        logic set_err;
        logic clr_err;
    } div_strobe_t;

endpackage

// File: rtl/div_ctrl_if.sv
// Host handshake plus datapath status/strobe bundle around the divider controller.
interface div_ctrl_if;

    // Host handshake
    logic start;
    logic ready;
    logic busy;
    logic done;
    logic done_ack;
    logic wdog_trip;

    // Datapath status
    logic b_is_zero;
    logic cnt_fin;

    // Datapath strobes
    logic ld_A;
    logic sel_A_init;
    logic ld_B;
    logic sel_B_init;
    logic ld_Q;
    logic clr_Q;
    logic ld_cnt;
    logic cnt_init;
    logic set_err;
    logic clr_err;

    // Controller side.
    modport slave (
        input  start, done_ack, b_is_zero, cnt_fin,
        output ready, busy, done, wdog_trip,
        output ld_A, sel_A_init, ld_B, sel_B_init, ld_Q, clr_Q,
        output ld_cnt, cnt_init, set_err, clr_err
    );

    // Host and datapath side.
    modport master (
        output start, done_ack, b_is_zero, cnt_fin,
        input  ready, busy, done, wdog_trip,
        input  ld_A, sel_A_init, ld_B, sel_B_init, ld_Q, clr_Q,
        input  ld_cnt, cnt_init, set_err, clr_err
    );

endinterface

// File: rtl/div_ctrl.sv
// Sequencing FSM for the 8-bit restoring divider: operand accept, 9 RUN
// iterations guarded by a watchdog, and a DONE state that either pulses for
// one cycle (DONE_MODE=0) or waits for done_ack (DONE_MODE=1).
module div_ctrl
    import div_pkg::*;
#(
    parameter int DONE_MODE = 0,
    // Watchdog limit in RUN cycles; meaningful range is DIV_ITER..2**CNT_W.
    parameter int MAX_ITER  = DIV_ITER
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    div_state_t        state;
    div_state_t        state_nxt;
    logic [CNT_W-1:0]  iter_cnt;
    logic [CNT_W:0]    run_num;
    logic              accept;
    logic              wdog_fire;
    logic              wdog_q;
    div_strobe_t       stb;

    // A request is taken only while idle; ready is the idle indicator.
    assign accept    = (state == IDLE) && bus.start;

    // 1-based index of the current RUN cycle.
    assign run_num   = {1'b0, iter_cnt} + 1'b1;

    // Watchdog fires on the MAX_ITER-th RUN cycle if the datapath has not finished.
    assign wdog_fire = (state == RUN) && !bus.cnt_fin && (run_num >= (CNT_W+1)'(MAX_ITER));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Saturating RUN-cycle counter and sticky watchdog flag, both restarted by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            if (accept)
                iter_cnt <= '0;
            else if ((state == RUN) && (iter_cnt != {CNT_W{1'b1}}))
                iter_cnt <= iter_cnt + 1'b1;

            if (accept)
                wdog_q <= 1'b0;
            else if (wdog_fire)
                wdog_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = bus.b_is_zero ? DONE : RUN;
            RUN:  if (bus.cnt_fin || wdog_fire) state_nxt = DONE;
            DONE: if ((DONE_MODE == 0) || bus.done_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath strobe decoder (Mealy in IDLE), silenced while rst is high
    always_comb begin
        stb = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.b_is_zero) begin
                            // Zero divisor: flag the error, clear the quotient, skip the run.
                            stb.set_err = 1'b1;
                            stb.clr_q   = 1'b1;
                        end else begin
                            stb.ld_a       = 1'b1;
                            stb.sel_a_init = 1'b1;
                            stb.ld_b       = 1'b1;
                            stb.sel_b_init = 1'b1;
                            stb.clr_q      = 1'b1;
                            stb.ld_cnt     = 1'b1;
                            stb.cnt_init   = 1'b1;
                            stb.clr_err    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // One shift/subtract step; a watchdog cycle keeps the quotient and flags an error.
                    stb.ld_a    = 1'b1;
                    stb.ld_b    = 1'b1;
                    stb.ld_q    = !wdog_fire;
                    stb.ld_cnt  = 1'b1;
                    stb.set_err = wdog_fire;
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_A       = stb.ld_a;
    assign bus.sel_A_init = stb.sel_a_init;
    assign bus.ld_B       = stb.ld_b;
    assign bus.sel_B_init = stb.sel_b_init;
    assign bus.ld_Q       = stb.ld_q;
    assign bus.clr_Q      = stb.clr_q;
    assign bus.ld_cnt     = stb.ld_cnt;
    assign bus.cnt_init   = stb.cnt_init;
    assign bus.set_err    = stb.set_err;
    assign bus.clr_err    = stb.clr_err;

    assign bus.ready      = (state == IDLE);
    assign bus.busy       = (state == RUN) || (state == DONE);
    assign bus.done       = (state == DONE);
    assign bus.wdog_trip  = wdog_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl. Instance 0 (DONE_MODE=0, MAX_ITER=9) drives a
// behavioural restoring-divider datapath; results are compared against / and %.
// Instance 1 (DONE_MODE=1, MAX_ITER=11) covers the acknowledge mode and a longer watchdog.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int MAX0 = 9;
    localparam int MAX1 = 11;

    // Strobe vectors: {ld_A, sel_A_init, ld_B, sel_B_init, ld_Q, clr_Q, ld_cnt, cnt_init, set_err, clr_err}
    localparam logic [9:0] S_ACC = 10'b1111011101;
    localparam logic [9:0] S_BZ  = 10'b0000010010;
    localparam logic [9:0] S_RUN = 10'b1010101000;
    localparam logic [9:0] S_WDG = 10'b1010001010;
    localparam logic [9:0] S_OFF = 10'b0000000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_ctrl_if h0();
    div_ctrl_if h1();

    div_ctrl #(.DONE_MODE(0), .MAX_ITER(MAX0)) dut0 (.clk(clk), .rst(rst), .bus(h0));
    div_ctrl #(.DONE_MODE(1), .MAX_ITER(MAX1)) dut1 (.clk(clk), .rst(rst), .bus(h1));

    int total = 0;
    int bad   = 0;

    logic [DIV_W-1:0] din_a0, din_b0, din_b1;
    logic no_fin0, no_fin1;

    // Behavioural datapath for instance 0: 16-bit remainder, divisor pre-shifted by DIV_W.
    logic [15:0] m_a, m_b;
    logic [8:0]  m_q;
    logic [3:0]  m_cnt, m1_cnt;
    logic        m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_a <= '0; m_b <= '0; m_q <= '0; m_cnt <= '0; m_err <= 1'b0;
        end else begin
            if (h0.ld_A)   m_a <= h0.sel_A_init ? {8'h00, din_a0} : ((m_a >= m_b) ? m_a - m_b : m_a);
            if (h0.ld_B)   m_b <= h0.sel_B_init ? {din_b0, 8'h00} : (m_b >> 1);
            if (h0.clr_Q)  m_q <= '0;
            else if (h0.ld_Q) m_q <= {m_q[7:0], (m_a >= m_b)};
            if (h0.ld_cnt) m_cnt <= h0.cnt_init ? 4'd9 : m_cnt - 4'd1;
            if (h0.clr_err) m_err <= 1'b0;
            else if (h0.set_err) m_err <= 1'b1;
        end
    end

    // Iteration counter only, for instance 1.
    always @(posedge clk) begin
        if (rst) m1_cnt <= '0;
        else if (h1.ld_cnt) m1_cnt <= h1.cnt_init ? 4'd9 : m1_cnt - 4'd1;
    end

    assign h0.b_is_zero = (din_b0 == '0);
    assign h0.cnt_fin   = (m_cnt == 4'd1) && !no_fin0;
    assign h1.b_is_zero = (din_b1 == '0);
    assign h1.cnt_fin   = (m1_cnt == 4'd1) && !no_fin1;

    function automatic logic [9:0] stb0();
        return {h0.ld_A, h0.sel_A_init, h0.ld_B, h0.sel_B_init, h0.ld_Q, h0.clr_Q,
                h0.ld_cnt, h0.cnt_init, h0.set_err, h0.clr_err};
    endfunction

    function automatic logic [9:0] stb1();
        return {h1.ld_A, h1.sel_A_init, h1.ld_B, h1.sel_B_init, h1.ld_Q, h1.clr_Q,
                h1.ld_cnt, h1.cnt_init, h1.set_err, h1.clr_err};
    endfunction

    // One complete divide on instance 0 with latency, strobe and result checks.
    task automatic div0(input logic [7:0] a, input logic [7:0] b, input string tag);
        int          cyc;
        int          exp_lat;
        logic [8:0]  exp_q;
        logic [7:0]  exp_r;
        exp_lat = (b == 0) ? 1 : 10;
        exp_q   = (b == 0) ? 9'd0 : {1'b0, a / b};
        exp_r   = (b == 0) ? 8'd0 : a % b;
        @(negedge clk); din_a0 = a; din_b0 = b; h0.start = 1'b1; #1;
        total++; if (h0.ready !== 1'b1) begin bad++; $display("FAIL %s accept_ready got=%b want=1", tag, h0.ready); end
        total++; if (stb0() !== ((b == 0) ? S_BZ : S_ACC)) begin bad++; $display("FAIL %s accept_strobes got=%b want=%b", tag, stb0(), (b == 0) ? S_BZ : S_ACC); end
        cyc = 0;
        do begin
            @(negedge clk); h0.start = 1'b0; #1; cyc++;
            if (!h0.done) begin
                total++;
                if (stb0() !== S_RUN || h0.busy !== 1'b1 || h0.ready !== 1'b0) begin
                    bad++; $display("FAIL %s run_cycle%0d strobes=%b busy=%b ready=%b want %b/1/0", tag, cyc, stb0(), h0.busy, h0.ready, S_RUN);
                end
            end
        end while (!h0.done && cyc < 30);
        total++; if (cyc !== exp_lat) begin bad++; $display("FAIL %s done_latency got=%0d want=%0d", tag, cyc, exp_lat); end
        total++; if (stb0() !== S_OFF) begin bad++; $display("FAIL %s done_strobes got=%b want=0", tag, stb0()); end
        total++; if (m_q !== exp_q) begin bad++; $display("FAIL %s quotient got=%0d want=%0d", tag, m_q, exp_q); end
        if (b != 0) begin
            total++; if (m_a[7:0] !== exp_r) begin bad++; $display("FAIL %s remainder got=%0d want=%0d", tag, m_a[7:0], exp_r); end
        end
        total++; if (m_err !== (b == 0)) begin bad++; $display("FAIL %s div_err got=%b want=%b", tag, m_err, (b == 0)); end
        @(negedge clk); #1;
        total++; if (h0.ready !== 1'b1 || h0.done !== 1'b0) begin bad++; $display("FAIL %s back_to_idle ready=%b done=%b want 1/0", tag, h0.ready, h0.done); end
    endtask

    task automatic test_reset();
        rst = 1'b1; din_b0 = 8'd5; din_b1 = 8'd5; h0.start = 1'b1; h1.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (stb0() !== S_OFF || stb1() !== S_OFF) begin bad++; $display("FAIL reset_strobes cyc%0d got=%b/%b want=0", i, stb0(), stb1()); end
        end
        @(negedge clk); rst = 1'b0; h0.start = 1'b0; h1.start = 1'b0; #1;
        total++; if ({h0.ready, h0.busy, h0.done, h0.wdog_trip} !== 4'b1000) begin bad++; $display("FAIL reset_state0 rdy/busy/done/wdog got=%b want=1000", {h0.ready, h0.busy, h0.done, h0.wdog_trip}); end
        total++; if ({h1.ready, h1.busy, h1.done, h1.wdog_trip} !== 4'b1000) begin bad++; $display("FAIL reset_state1 rdy/busy/done/wdog got=%b want=1000", {h1.ready, h1.busy, h1.done, h1.wdog_trip}); end
    endtask

    task automatic test_divide();
        div0(8'd100, 8'd7,   "normal_100_7");
        div0(8'd200, 8'd0,   "div_zero_200_0");
        div0(8'd10,  8'd5,   "after_zero_10_5");
        div0(8'd255, 8'd1,   "edge_255_1");
        div0(8'd3,   8'd9,   "edge_3_9");
        div0(8'd0,   8'd255, "edge_0_255");
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            div0(a, b, $sformatf("rand%0d_%0d_%0d", n, a, b));
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int ready_hits;
        @(negedge clk); din_a0 = 8'd100; din_b0 = 8'd7; h0.start = 1'b1; #1;
        total++; if (stb0() !== S_ACC) begin bad++; $display("FAIL held_first_accept got=%b want=%b", stb0(), S_ACC); end
        ready_hits = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            if (h0.ready !== 1'b0) ready_hits++;
        end
        total++; if (ready_hits !== 0) begin bad++; $display("FAIL held_ready_busy_window got=%0d ready cycles want=0", ready_hits); end
        @(negedge clk); #1;
        total++; if (h0.ready !== 1'b1 || stb0() !== S_ACC) begin bad++; $display("FAIL held_second_accept ready=%b strobes=%b want 1/%b", h0.ready, stb0(), S_ACC); end
        cyc = 0;
        do begin
            @(negedge clk); h0.start = 1'b0; #1; cyc++;
        end while (!h0.done && cyc < 30);
        total++; if (cyc !== 10 || m_q !== 9'd14 || m_a[7:0] !== 8'd2) begin bad++; $display("FAIL held_second_result lat=%0d q=%0d r=%0d want 10/14/2", cyc, m_q, m_a[7:0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); din_a0 = 8'd100; din_b0 = 8'd7; h0.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); h0.start = 1'b0;
        end
        #1;
        total++; if (stb0() !== S_RUN) begin bad++; $display("FAIL mid_run_before_rst got=%b want=%b", stb0(), S_RUN); end
        rst = 1'b1; #1;
        total++; if (stb0() !== S_OFF) begin bad++; $display("FAIL mid_rst_strobes got=%b want=0", stb0()); end
        @(negedge clk); #1;
        total++; if (stb0() !== S_OFF || h0.ready !== 1'b1 || h0.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_idle strobes=%b ready=%b busy=%b want 0/1/0", stb0(), h0.ready, h0.busy); end
        @(negedge clk); rst = 1'b0;
        div0(8'd100, 8'd7, "after_mid_rst");
    endtask

    task automatic test_watchdog0();
        int cyc;
        no_fin0 = 1'b1;
        @(negedge clk); din_a0 = 8'd50; din_b0 = 8'd3; h0.start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); h0.start = 1'b0; #1; cyc++;
        end while (h0.set_err !== 1'b1 && cyc < 30);
        total++; if (cyc !== MAX0 || stb0() !== S_WDG) begin bad++; $display("FAIL wdog0_fire cyc=%0d strobes=%b want %0d/%b", cyc, stb0(), MAX0, S_WDG); end
        @(negedge clk); #1;
        total++; if (h0.done !== 1'b1 || h0.wdog_trip !== 1'b1 || m_err !== 1'b1) begin bad++; $display("FAIL wdog0_done done=%b trip=%b err=%b want 1/1/1", h0.done, h0.wdog_trip, m_err); end
        @(negedge clk); #1;
        total++; if (h0.ready !== 1'b1 || h0.wdog_trip !== 1'b1) begin bad++; $display("FAIL wdog0_sticky ready=%b trip=%b want 1/1", h0.ready, h0.wdog_trip); end
        no_fin0 = 1'b0;
        div0(8'd20, 8'd4, "after_wdog0");
        total++; if (h0.wdog_trip !== 1'b0) begin bad++; $display("FAIL wdog0_clear got=%b want=0", h0.wdog_trip); end
    endtask

    task automatic test_done_ack();
        int cyc;
        int held;
        @(negedge clk); din_b1 = 8'd7; h1.start = 1'b1; #1;
        total++; if (h1.ready !== 1'b1 || stb1() !== S_ACC) begin bad++; $display("FAIL ack_accept ready=%b strobes=%b want 1/%b", h1.ready, stb1(), S_ACC); end
        cyc = 0;
        do begin
            @(negedge clk); h1.start = 1'b0; h1.done_ack = (cyc == 2); #1; cyc++;
        end while (!h1.done && cyc < 30);
        h1.done_ack = 1'b0;
        total++; if (cyc !== 10) begin bad++; $display("FAIL ack_latency got=%0d want=10", cyc); end
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (h1.done === 1'b1 && h1.ready === 1'b0 && stb1() === S_OFF) held++;
        end
        total++; if (held !== 20) begin bad++; $display("FAIL ack_hold got=%0d cycles want=20", held); end
        @(negedge clk); h1.done_ack = 1'b1; #1;
        total++; if (h1.done !== 1'b1) begin bad++; $display("FAIL ack_same_cycle done=%b want=1", h1.done); end
        @(negedge clk); h1.done_ack = 1'b0; #1;
        total++; if (h1.ready !== 1'b1 || h1.done !== 1'b0) begin bad++; $display("FAIL ack_release ready=%b done=%b want 1/0", h1.ready, h1.done); end
    endtask

    task automatic test_watchdog1();
        int cyc;
        no_fin1 = 1'b1;
        @(negedge clk); din_b1 = 8'd2; h1.start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); h1.start = 1'b0; #1; cyc++;
        end while (h1.set_err !== 1'b1 && cyc < 30);
        total++; if (cyc !== MAX1 || stb1() !== S_WDG) begin bad++; $display("FAIL wdog1_fire cyc=%0d strobes=%b want %0d/%b", cyc, stb1(), MAX1, S_WDG); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (h1.done !== 1'b1 || h1.wdog_trip !== 1'b1) begin bad++; $display("FAIL wdog1_hold done=%b trip=%b want 1/1", h1.done, h1.wdog_trip); end
        @(negedge clk); h1.done_ack = 1'b1;
        @(negedge clk); h1.done_ack = 1'b0; #1;
        total++; if (h1.ready !== 1'b1 || h1.wdog_trip !== 1'b1) begin bad++; $display("FAIL wdog1_release ready=%b trip=%b want 1/1", h1.ready, h1.wdog_trip); end
        no_fin1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        h0.start = 1'b0; h0.done_ack = 1'b0;
        h1.start = 1'b0; h1.done_ack = 1'b0;
        din_a0 = '0; din_b0 = '0; din_b1 = '0;
        no_fin0 = 1'b0; no_fin1 = 1'b0;
        test_reset();
        test_divide();
        test_back_to_back();
        test_reset_mid();
        test_watchdog0();
        test_done_ack();
        test_watchdog1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- FSM controller that sequences the 8-bit restoring divider datapath (div_dp).
- Accepts operands through a start/ready handshake and validates the divisor.
- Drives every datapath load/select/clear strobe for a 9-iteration divide.
- Reports completion via done, with an optional hold-until-ack mode. Sits between the requesting host logic and div_dp.

Parameters:
- DONE_MODE, 0: 0 = done is a 1-cycle pulse; 1 = done held until done_ack.
- MAX_ITER, 9: watchdog limit on RUN cycles; must be at least 9.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; din_A/din_B must be valid at div_dp in the same cycle
- ready  out  1  high in IDLE only; start is accepted when start&&ready
- busy  out  1  high in RUN and DONE
- done  out  1  result valid (quo/rem/div_err are stable at div_dp)
- done_ack  in  1  host acknowledge; used only when DONE_MODE=1
- b_is_zero  in  1  from datapath, divisor-zero detect on din_B
- cnt_fin  in  1  from datapath, iteration counter == 1
- ld_A, sel_A_init, ld_B, sel_B_init, ld_Q, clr_Q, ld_cnt, cnt_init, set_err, clr_err  out  1 each  datapath strobes
- wdog_trip  out  1  sticky; set when the watchdog fires, cleared by rst or by the next accepted start

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst is high, every output strobe is forced to 0. After reset: state=IDLE, ready=1, busy=0, done=0, wdog_trip=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, b_is_zero=0 (Mealy, same cycle):
  - Assert ld_A, sel_A_init, ld_B, sel_B_init, clr_Q, ld_cnt, cnt_init, clr_err.
  - Clear wdog_trip. Next state is RUN.
- IDLE, start=1, b_is_zero=1:
  - Assert set_err and clr_Q only. A, B and CNT are not loaded. Next state is DONE.
- IDLE, start=0: all strobes 0; stay in IDLE.
- RUN, every cycle:
  - Assert ld_A, ld_B, ld_Q, ld_cnt with sel_A_init=0, sel_B_init=0, cnt_init=0.
  - The internal iteration counter increments.
  - If cnt_fin=1, this is the last iteration; next state is DONE.
- Watchdog: if the internal counter reaches MAX_ITER in RUN with cnt_fin still 0:
  - That cycle asserts set_err, suppresses ld_Q, sets wdog_trip, and goes to DONE.
- DONE:
  - done=1 and all strobes are 0.
  - DONE_MODE=0: return to IDLE after 1 cycle.
  - DONE_MODE=1: stay in DONE until done_ack=1, then go to IDLE on the next edge.
- Latency (start accept = cycle 0):
  - Normal divide: 9 RUN cycles (1..9), done at cycle 10, ready again at cycle 11 when DONE_MODE=0.
  - Divide-by-zero: done at cycle 1.
- Ignored inputs: start outside IDLE is ignored (ready=0). done_ack outside DONE, or with DONE_MODE=0, is ignored.
- start held high across DONE→IDLE is accepted as a new request on the first IDLE cycle.
- Reset mid-operation: the next edge returns to IDLE. The datapath registers are cleared by the datapath's own reset.
- Internal iteration counter: 4 bits, saturating, cleared on start accept.

Decomposition:
- Package div_pkg holds:
  - the state enum typedef (div_state_t: IDLE, RUN, DONE);
  - localparam DIV_ITER=9;
  - localparam DIV_W=8.
- No sub-module: a single FSM with a registered state, a combinational strobe decoder and the watchdog counter.
- A top level div_top instantiates div_ctrl and div_dp (out of scope here).

Test Plan:
- Normal divide: A=100, B=7, start pulse in IDLE → 9 RUN cycles, done at cycle 10; quo=14, rem=2, div_err=0.
- Divide-by-zero: A=200, B=0 → set_err in the accept cycle, done at cycle 1; div_err=1, quo=0. The next start with B=5, A=10 gives div_err=0, quo=2, rem=0.
- Edge operands: A=255, B=1 → quo=255, rem=0. A=3, B=9 → quo=0, rem=3. A=0, B=255 → quo=0, rem=0.
- start held high through RUN: only one accept; ready stays 0 during cycles 1..10. A second accept occurs at cycle 11 (DONE_MODE=0).
- rst asserted at RUN cycle 5 → all strobes 0 while rst is high, then IDLE with ready=1. A fresh 100/7 then completes correctly.
- Mode and watchdog:
  - DONE_MODE=1: done stays high for 20 cycles until done_ack, then ready=1 on the next cycle.
  - Standalone bench with cnt_fin tied 0: wdog_trip=1 and set_err after MAX_ITER RUN cycles, then done.
